// File: rtl/pwm_meter_pkg.sv
// Shared types and defaults for the PWM period/high-time meter.
package pwm_meter_pkg;
  localparam int PWM_W_DEF    = 32;
  localparam int PWM_SYNC_DEF = 2;
  localparam int PWM_FLT_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;
endpackage

// File: rtl/pwm_meter_sync_edge.sv
// Synchronizer, optional stability filter (PWM_METER_GLITCH_FILTER_EN) and
// rise/fall pulse generation for the asynchronous PWM input.
module pwm_meter_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int FLT_LEN     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = level;
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int CW = $clog2(FLT_LEN + 1);
  logic          flt_q, flt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  // A new level is taken on the FLT_LEN-th consecutive disagreeing cycle,
  // so both edges see the same added latency.
  always_comb begin
    flt_d  = flt_q;
    fcnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != flt_q) begin
      if (fcnt_q == CW'(FLT_LEN - 1)) flt_d  = sync_q[SYNC_STAGES-1];
      else                             fcnt_d = fcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q  <= 1'b0;
      fcnt_q <= '0;
    end else begin
      flt_q  <= flt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = flt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/pwm_meter.sv
// PWM receive meter: period and high time in clk cycles, stuck detect,
// saturation flag. PWM_METER_GLITCH_FILTER_EN enables the input filter.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int W           = PWM_W_DEF,
  parameter int SYNC_STAGES = PWM_SYNC_DEF,
  parameter int FLT_LEN     = PWM_FLT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pwm_in,
  input  logic [W-1:0] timeout,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         ovf,
  output logic         valid,
  output logic         stuck,
  output logic         stuck_level
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic level, rise, fall, any_edge, tmo_hit;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, idle_q, idle_d;
  logic [W-1:0] period_q, period_d, high_q, high_d;
  logic         sat_q, sat_d, ovf_q, ovf_d, valid_q, valid_d;
  logic         stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;

  pwm_meter_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .FLT_LEN(FLT_LEN)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign any_edge = rise | fall;
  // An edge in the same cycle as the limit suppresses the stuck report.
  assign tmo_hit  = (timeout != '0) && !any_edge && (idle_q >= timeout - W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    idle_d      = idle_q;
    sat_d       = sat_q;
    period_d    = period_q;
    high_d      = high_q;
    ovf_d       = ovf_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      idle_d  = '0;
      sat_d   = 1'b0;
      stuck_d = 1'b0;
    end else begin
      idle_d = (any_edge || timeout == '0) ? '0 : idle_q + W'(1);
      if (any_edge) stuck_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          idle_d  = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
            cnt_d   = W'(1);
            hcnt_d  = W'(1);
            sat_d   = 1'b0;
          end
        end
        S_HIGH: begin
          if (cnt_q == CNT_MAX) sat_d = 1'b1;
          else                  cnt_d = cnt_q + W'(1);
          if (fall) begin
            state_d = S_LOW;
          end else if (hcnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + W'(1);
          end
        end
        S_LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            ovf_d    = sat_q;
            valid_d  = 1'b1;
            state_d  = S_HIGH;
            cnt_d    = W'(1);
            hcnt_d   = W'(1);
            sat_d    = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (tmo_hit && state_q != S_IDLE) begin
        stuck_d     = 1'b1;
        stuck_lvl_d = level;
        state_d     = S_ARM;
        cnt_d       = '0;
        hcnt_d      = '0;
        idle_d      = '0;
        sat_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      idle_q      <= '0;
      sat_q       <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      idle_q      <= idle_d;
      sat_q       <= sat_d;
      period_q    <= period_d;
      high_q      <= high_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign ovf         = ovf_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;
endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: a waveform-level model predicts each
// reported cycle, a monitor checks every valid strobe against the queue.
module tb_pwm_meter;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, en, pwm_in;
  logic [W-1:0] timeout, period, high_time;
  logic         ovf, valid, stuck, stuck_level;

  always #5 clk = ~clk;

  pwm_meter #(.W(W), .SYNC_STAGES(2), .FLT_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pwm_in      (pwm_in),
    .timeout     (timeout),
    .period      (period),
    .high_time   (high_time),
    .ovf         (ovf),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  typedef struct {
    int p;
    int h;
    bit o;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0;

  // Waveform model: time in input cycles, edges at phase boundaries.
  int cyc = 0, rise_cyc = 0, fall_cyc = 0, last_edge = 0, tmo = 0;
  bit cur = 1'b0, have_rise = 1'b0, have_fall = 1'b0;
  int last_p = 0, last_h = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_phase(input bit lvl, input int n);
    exp_t e;
    if (lvl != cur) begin
      if (tmo != 0 && cyc - last_edge > tmo) have_rise = 1'b0;
      last_edge = cyc;
      if (lvl) begin
        if (have_rise && have_fall) begin
          e.p = (cyc - rise_cyc > MAX) ? MAX : cyc - rise_cyc;
          e.h = (fall_cyc - rise_cyc > MAX) ? MAX : fall_cyc - rise_cyc;
          e.o = (cyc - rise_cyc > MAX);
          q.push_back(e);
          last_p = e.p;
          last_h = e.h;
        end
        have_rise = 1'b1;
        have_fall = 1'b0;
        rise_cyc  = cyc;
      end else if (have_rise) begin
        have_fall = 1'b1;
        fall_cyc  = cyc;
      end
      cur = lvl;
    end
    cyc += n;
  endtask

  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic phase(input bit lvl, input int n);
    model_phase(lvl, n);
    drive(lvl, n);
  endtask

  // Monitor: every valid strobe must match the oldest prediction.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid) begin
      n_vec++;
      if (prev_valid) begin
        n_err++;
        $display("FAIL valid_back_to_back: valid high two cycles running");
      end
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: period=%0d high=%0d ovf=%0d, none expected",
                 period, high_time, ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_vec++;
        if (int'(period) != e.p || int'(high_time) != e.h || ovf != e.o) begin
          n_err++;
          $display("FAIL measurement: got p=%0d h=%0d o=%0d expected p=%0d h=%0d o=%0d",
                   period, high_time, ovf, e.p, e.h, e.o);
        end
      end
    end
    prev_valid <= valid;
  end

  initial begin
    int sweep[3];
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; timeout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", period, 0);
    chk("reset_high", high_time, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_valid", valid, 0);
    chk("reset_stuck", stuck, 0);
    chk("reset_stuck_level", stuck_level, 0);
    rst = 1'b0;
    en  = 1'b1;

    // 5/5 basic cycles
    phase(0, 10);
    repeat (4) begin phase(1, 5); phase(0, 5); end

    // duty sweep at period 20
`ifdef PWM_METER_GLITCH_FILTER_EN
    sweep = '{5, 10, 15};
`else
    sweep = '{1, 10, 19};
`endif
    foreach (sweep[i]) begin phase(1, sweep[i]); phase(0, 20 - sweep[i]); end

    // randomized waveform
    repeat (40) begin
      phase(1, $urandom_range(5, 40));
      phase(0, $urandom_range(5, 40));
    end

    // saturation, exact full-scale period, recovery
    phase(1, 300); phase(0, 10);
    phase(1, 5);   phase(0, 5);
    phase(1, 200); phase(0, 55);
    phase(1, 5);   phase(0, 5);

    // en dropped mid-LOW: results hold, no report
    phase(1, 10); phase(0, 12);
    en = 1'b0; have_rise = 1'b0; have_fall = 1'b0;
    phase(0, 6);
    chk("en_hold_period", period, last_p);
    chk("en_hold_high", high_time, last_h);
    chk("en_hold_valid", valid, 0);
    en = 1'b1; last_edge = cyc;
    phase(0, 10);
    repeat (3) begin phase(1, 5); phase(0, 5); end

    // async reset mid-HIGH
    phase(0, 10); phase(1, 12);
    rst = 1'b1; pwm_in = 1'b0; cur = 1'b0; have_rise = 1'b0; have_fall = 1'b0;
    #1;
    chk("rst_mid_period", period, 0);
    chk("rst_mid_high", high_time, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_stuck", stuck, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cyc += 2; last_edge = cyc;
    phase(0, 10);
    repeat (3) begin phase(1, 5); phase(0, 5); end

    // stuck high with timeout 50, then recovery
    tmo = 50; timeout = W'(50);
    phase(1, 6); phase(0, 6);
    phase(1, 30);
    chk("stuck_early", stuck, 0);
    phase(1, 90);
    chk("stuck_set", stuck, 1);
    chk("stuck_level_high", stuck_level, 1);
    phase(0, 10);
    chk("stuck_cleared", stuck, 0);
    phase(1, 10); phase(0, 10); phase(1, 10); phase(0, 10);
    tmo = 0; timeout = '0;

    // 2-cycle low glitch inside a 10-cycle high phase
    phase(1, 10); phase(0, 10);
`ifdef PWM_METER_GLITCH_FILTER_EN
    model_phase(1, 10);
`else
    model_phase(1, 4); model_phase(0, 2); model_phase(1, 4);
`endif
    drive(1, 4); drive(0, 2); drive(1, 4);
    phase(0, 10); phase(1, 10); phase(0, 10); phase(1, 5);
    phase(0, 20);

    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
